// File: rtl/fifo_wr_arbiter_rr_pkg.sv
// rtl/fifo_wr_arbiter_rr_pkg.sv - shared types and width helper for the FIFO write-side arbiter
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero for a single-entry vector
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// rtl/arbiter_rr_pick.sv - combinational round-robin picker, search starts after the last winner
module arbiter_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last_idx,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW:0]    w_start;
    logic [IW:0]    w_pos;
    logic [IW:0]    w_sum;

    // Doubling the vector turns the wrap-around search into a plain shift plus lowest-bit encode
    always_comb begin
        w_start = (i_last_idx >= IW'(N - 1)) ? '0 : ({1'b0, i_last_idx} + (IW+1)'(1));
        w_dbl   = {i_req, i_req};
        w_rot   = N'(w_dbl >> w_start);
        w_pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_pos = (IW+1)'(k);
            end
        end
        w_sum = w_start + w_pos;
        if (w_sum >= (IW+1)'(N)) begin
            w_sum = w_sum - (IW+1)'(N);
        end
        o_valid = |i_req;
        o_idx   = o_valid ? w_sum[IW-1:0] : '0;
        o_grant = o_valid ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter_rr.sv
// rtl/fifo_wr_arbiter_rr.sv - round-robin burst arbiter sharing one FIFO write port among N requesters
module fifo_wr_arbiter_rr
    import fifo_arb_pkg::*;
#(
    parameter int N               = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_BURST       = 4,
    parameter int USE_ALMOST_FULL = 0,
    localparam int IW = clog2w(N),
    localparam int CW = clog2w(MAX_BURST + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N-1:0]            i_req,
    input  logic [N*DATA_WIDTH-1:0] i_data,
    input  logic [N-1:0]            i_last,
    output logic [N-1:0]            o_ack,
    output logic [N-1:0]            o_grant,
    output logic [IW-1:0]           o_grant_id,
    output logic                    o_wr_write,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    input  logic                    i_wr_full,
    input  logic                    i_wr_almost_full
);

    arb_state_t      r_state;
    logic [N-1:0]    r_grant;
    logic [IW-1:0]   r_grant_id;
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;

    logic [N-1:0]    w_pick_grant;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_valid;
    logic            w_stall;
    logic            w_busy;
    logic            w_req_g;
    logic            w_xfer;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_burst_end;

    arbiter_rr_pick #(.N(N)) u_pick (
        .i_req      (i_req),
        .i_last_idx (r_ptr),
        .o_grant    (w_pick_grant),
        .o_idx      (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

    assign w_stall     = i_wr_full | ((USE_ALMOST_FULL != 0) & i_wr_almost_full);
    assign w_busy      = (r_state == ARB_BURST);
    assign w_req_g     = i_req[r_grant_id];
    assign w_xfer      = w_busy & w_req_g & ~w_stall;
    assign w_cnt_nxt   = r_cnt + CW'(1);
    assign w_burst_end = i_last[r_grant_id] | (w_cnt_nxt == CW'(MAX_BURST));

    // Datapath is a pure mux off the registered grant: data leaves in the same cycle it is accepted
    assign o_grant    = r_grant;
    assign o_grant_id = r_grant_id;
    assign o_wr_write = w_xfer;
    assign o_ack      = r_grant & {N{w_xfer}};
    assign o_wr_data  = w_busy ? i_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ARB_IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_cnt      <= '0;
            r_ptr      <= IW'(N - 1);
        end else begin
            unique case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= ARB_BURST;
                        r_grant    <= w_pick_grant;
                        r_grant_id <= w_pick_idx;
                        r_ptr      <= w_pick_idx;
                        r_cnt      <= '0;
                    end
                end
                ARB_BURST: begin
                    if (w_xfer) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_burst_end) begin
                            r_state    <= ARB_IDLE;
                            r_grant    <= '0;
                            r_grant_id <= '0;
                        end
                    end else if (!w_stall && !w_req_g) begin
                        // Withdrawn requester forfeits the rest of its burst
                        r_state    <= ARB_IDLE;
                        r_grant    <= '0;
                        r_grant_id <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    a_req_held_on_stall: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (w_busy && w_req_g && w_stall) |=> w_req_g);
    a_no_write_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_wr_write && i_wr_full));
    a_grant_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_grant));
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter_rr.sv
// tb/tb_fifo_wr_arbiter_rr.sv - scoreboard bench for the round-robin FIFO write arbiter
module tb_fifo_wr_arbiter_rr;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*DW-1:0] data;
    logic [N-1:0]    last;
    logic            full;
    logic            afull;
    logic [DW-1:0]   dat [N];

    logic [N-1:0]    ack,     ack_af;
    logic [N-1:0]    grant,   grant_af;
    logic [IW-1:0]   gid,     gid_af;
    logic            wr,      wr_af;
    logic [DW-1:0]   wdata,   wdata_af;

    int checks = 0;
    int errors = 0;
    logic [IW+DW-1:0] sb [$];
    logic [IW+DW-1:0] sb_e;

    always #5 clk = ~clk;

    always_comb begin
        data = '0;
        for (int k = 0; k < N; k++) data[k*DW +: DW] = dat[k];
    end

    fifo_wr_arbiter_rr #(.N(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .USE_ALMOST_FULL(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .i_last(last),
        .o_ack(ack), .o_grant(grant), .o_grant_id(gid), .o_wr_write(wr), .o_wr_data(wdata),
        .i_wr_full(full), .i_wr_almost_full(afull)
    );

    fifo_wr_arbiter_rr #(.N(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .USE_ALMOST_FULL(1)) u_dut_af (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .i_last(last),
        .o_ack(ack_af), .o_grant(grant_af), .o_grant_id(gid_af), .o_wr_write(wr_af), .o_wr_data(wdata_af),
        .i_wr_full(full), .i_wr_almost_full(afull)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input int id, input logic [DW-1:0] d);
        sb.push_back({IW'(id), d});
    endtask

    // Every accepted beat on the main instance must match the next predicted {id, data}
    always @(negedge clk) begin
        if (wr) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_e = sb.pop_front();
                check_eq("sb_beat", {gid, wdata}, sb_e);
                check_eq("sb_ack", ack, N'(1) << sb_e[IW+DW-1:DW]);
            end
        end
    end

    initial begin
        logic [5:0]  exp1 [6];
        logic [12:0] p2;
        logic [10:0] p3;
        logic [9:0]  p4, g4, p4af, p5;
        logic [3:0]  g5 [10];
        logic [3:0]  g6 [8];
        logic [7:0]  p6;
        logic        got_ack;
        int          beats;

        rst_n = 1'b0; req = 4'b0101; last = 4'hF; full = 1'b0; afull = 1'b0;
        for (int k = 0; k < N; k++) dat[k] = 8'(8'hA0 + k);
        repeat (2) drive_edge();
        sample();
        check_eq("rst_grant", grant, 0);
        check_eq("rst_gid", gid, 0);
        check_eq("rst_wr", wr, 0);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_grant_af", grant_af, 0);
        drive_edge();

        // T1: 0 and 2 requesting single-beat bursts alternate with one idle cycle between
        exp1 = '{6'd0, 6'd1, 6'd0, 6'd4, 6'd0, 6'd1};
        push(0, 8'hA0); push(2, 8'hA2); push(0, 8'hA0);
        for (int c = 0; c < 6; c++) begin
            if (c == 0) rst_n = 1'b1;
            sample();
            check_eq("t1_grant", grant, exp1[c]);
            check_eq("t1_wr", wr, exp1[c] != 0);
            drive_edge();
        end

        // T2: lone requester 1 never says last; bursts cut at MAX_BURST
        req = 4'b0010; last = 4'h0; dat[1] = 8'h10;
        for (int i = 0; i < 10; i++) push(1, 8'(8'h10 + i));
        p2 = 13'b1101111011110;
        got_ack = 1'b0; beats = 0;
        for (int c = 0; c < 13; c++) begin
            if (got_ack) dat[1] = dat[1] + 8'd1;
            if (beats == 10) req = 4'b0000;
            sample();
            check_eq("t2_wr", wr, p2[c]);
            if (wr) check_eq("t2_gid", gid, 1);
            got_ack = ack[1];
            beats += int'(got_ack);
            drive_edge();
        end
        check_eq("t2_beats", beats, 10);
        req = 4'b0000;
        repeat (2) drive_edge();
        sample();
        check_eq("t2_idle", grant, 0);
        drive_edge();

        // T3: full stalls requester 3 after its second beat, burst resumes afterwards
        dat[3] = 8'h30;
        for (int i = 0; i < 4; i++) push(3, 8'(8'h30 + i));
        p3 = 11'b01100000110;
        got_ack = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (got_ack) dat[3] = dat[3] + 8'd1;
            req  = (c < 10) ? 4'b1000 : 4'b0000;
            full = (c >= 3 && c <= 7);
            sample();
            check_eq("t3_wr", wr, p3[c]);
            check_eq("t3_ack", ack, p3[c] ? 4'b1000 : 4'b0000);
            check_eq("t3_grant", grant, (c >= 1 && c <= 9) ? 4'b1000 : 4'b0000);
            got_ack = ack[3];
            drive_edge();
        end
        full = 1'b0;
        drive_edge();

        // T4: almost-full stalls only the instance configured to honour it
        dat[0] = 8'h40; last = 4'hF;
        for (int i = 0; i < 4; i++) push(0, 8'h40);
        p4   = 10'b0010101010;
        g4   = 10'b1010101010;
        p4af = 10'b0100000000;
        for (int c = 0; c < 10; c++) begin
            req   = (c < 9) ? 4'b0001 : 4'b0000;
            afull = (c < 8);
            sample();
            check_eq("t4_wr", wr, p4[c]);
            check_eq("t4_grant", grant, g4[c] ? 4'b0001 : 4'b0000);
            check_eq("t4_wr_af", wr_af, p4af[c]);
            check_eq("t4_grant_af", grant_af, (c >= 1 && c <= 8) ? 4'b0001 : 4'b0000);
            drive_edge();
        end
        afull = 1'b0;
        repeat (2) drive_edge();

        // T5: requester 2 withdraws after one beat; next search starts at 3
        dat[0] = 8'h60; dat[1] = 8'h61; dat[2] = 8'h52; dat[3] = 8'h63;
        last = 4'h0;
        push(2, 8'h52); push(3, 8'h63); push(0, 8'h60); push(1, 8'h61);
        g5 = '{4'd0, 4'd4, 4'd4, 4'd0, 4'd8, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0};
        p5 = 10'b0101010010;
        for (int c = 0; c < 10; c++) begin
            if (c < 2) req = 4'b0100;
            else if (c == 2) req = 4'b0000;
            else if (c < 9) begin req = 4'b1111; last = 4'hF; end
            else req = 4'b0000;
            sample();
            check_eq("t5_grant", grant, g5[c]);
            check_eq("t5_wr", wr, p5[c]);
            drive_edge();
        end
        repeat (2) drive_edge();

        // T6: reset mid-burst clears the grant and restores the index-0 search start
        dat[2] = 8'h70; dat[1] = 8'h71; last = 4'h0;
        push(2, 8'h70); push(2, 8'h70); push(1, 8'h71);
        g6 = '{4'd0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd2, 4'd2, 4'd0};
        p6 = 8'b00100110;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) rst_n = 1'b0;
            if (c == 3) req = 4'b1110;
            else if (c < 3) req = 4'b0100;
            if (c == 4) rst_n = 1'b1;
            if (c == 6) req = 4'b0000;
            sample();
            check_eq("t6_grant", grant, g6[c]);
            check_eq("t6_wr", wr, p6[c]);
            drive_edge();
        end
        repeat (3) drive_edge();
        check_eq("sb_left", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
